// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : Oversampled UART receiver. Recovers 1 start bit, 8 data bits
//             (LSB first), an optional parity bit and 1 stop bit from RX_IN.
//             Each bit is the 2-of-3 majority of samples taken around the
//             bit centre. A good frame updates P_DATA and pulses DATA_VALID
//             for one cycle.
//  Ports    : CLK        - oversampling clock (PRESCALE x baud), rising edge
//             RST        - synchronous active-low reset
//             RX_IN      - serial line, idles high (already synchronized)
//             PRESCALE   - CLK cycles per bit, even values 8..32
//             PAR_EN     - frame carries a parity bit
//             PAR_TYP    - 0 = even parity, 1 = odd parity
//             P_DATA     - last correctly received byte
//             DATA_VALID - one-cycle strobe when P_DATA is updated
//             PAR_ERR    - (UART_RX_ERR_FLAGS_EN only) parity error pulse
//             STP_ERR    - (UART_RX_ERR_FLAGS_EN only) stop error pulse
//  Options  : define UART_RX_ERR_FLAGS_EN to expose the error pulse ports.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      DATA_VALID
`ifdef UART_RX_ERR_FLAGS_EN
  ,
  output logic                      PAR_ERR,
  output logic                      STP_ERR
`endif
);

  localparam int BIT_CNT_WIDTH = $clog2(DATA_WIDTH);
  localparam logic [PRESCALE_WIDTH-1:0] c_one      = PRESCALE_WIDTH'(1);
  localparam logic [BIT_CNT_WIDTH-1:0]  c_last_bit = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e                    state_q,    state_d;
  logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic                      par_en_q,   par_en_d;
  logic                      par_typ_q,  par_typ_d;
  logic [2:0]                smp_q,      smp_d;
  logic [DATA_WIDTH-1:0]     data_q,     data_d;
  logic                      par_err_q,  par_err_d;
  logic [DATA_WIDTH-1:0]     p_data_q,   p_data_d;
  logic                      valid_q,    valid_d;
  logic                      flag_par_d, flag_stp_d;

  logic [PRESCALE_WIDTH-1:0] w_half;
  logic                      w_last_edge;
  logic                      w_maj;

  assign w_half      = {1'b0, prescale_q[PRESCALE_WIDTH-1:1]};
  assign w_last_edge = (edge_cnt_q == (prescale_q - c_one));
  // All three samples are settled well before the last edge of the bit,
  // which is the only point where the majority is consumed.
  assign w_maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = w_last_edge ? '0 : edge_cnt_q + c_one;
    bit_cnt_d  = bit_cnt_q;
    prescale_d = prescale_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    smp_d      = smp_q;
    data_d     = data_q;
    par_err_d  = par_err_q;
    p_data_d   = p_data_q;
    valid_d    = 1'b0;
    flag_par_d = 1'b0;
    flag_stp_d = 1'b0;

    if (edge_cnt_q == (w_half - c_one)) smp_d[0] = RX_IN;
    if (edge_cnt_q == w_half)           smp_d[1] = RX_IN;
    if (edge_cnt_q == (w_half + c_one)) smp_d[2] = RX_IN;

    case (state_q)
      S_IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!RX_IN) begin
          // This cycle is edge 0 of the start bit, so the count resumes at 1.
          state_d    = S_START;
          edge_cnt_d = c_one;
          prescale_d = PRESCALE;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_err_d  = 1'b0;
        end
      end
      S_START: begin
        if (w_last_edge) state_d = w_maj ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_last_edge) begin
          data_d[bit_cnt_q] = w_maj;
          if (bit_cnt_q == c_last_bit) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_last_edge) begin
          // Even parity: data XOR parity bit is 0; odd flips the expectation.
          par_err_d = (w_maj != ((^data_q) ^ par_typ_q));
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (w_last_edge) begin
          state_d    = S_IDLE;
          flag_par_d = par_err_q;
          flag_stp_d = ~w_maj;
          if (w_maj && !par_err_q) begin
            p_data_d = data_q;
            valid_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      smp_q      <= '0;
      data_q     <= '0;
      par_err_q  <= 1'b0;
      p_data_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      prescale_q <= prescale_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      smp_q      <= smp_d;
      data_q     <= data_d;
      par_err_q  <= par_err_d;
      p_data_q   <= p_data_d;
      valid_q    <= valid_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = valid_q;

`ifdef UART_RX_ERR_FLAGS_EN
  logic par_flag_q;
  logic stp_flag_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      par_flag_q <= 1'b0;
      stp_flag_q <= 1'b0;
    end else begin
      par_flag_q <= flag_par_d;
      stp_flag_q <= flag_stp_d;
    end
  end

  assign PAR_ERR = par_flag_q;
  assign STP_ERR = stp_flag_q;
`else
  // Error pulses have no destination; a bad frame simply produces no strobe.
  logic w_unused_flags;
  assign w_unused_flags = flag_par_d ^ flag_stp_d;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx: directed frame table,
//             hand-written corner sequences (back-to-back, start glitch,
//             mid-frame reset) and randomized frames against a frame-level
//             reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] PRESCALE = 6'd16;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
`ifdef UART_RX_ERR_FLAGS_EN
  logic       PAR_ERR;
  logic       STP_ERR;
`endif

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID)
`ifdef UART_RX_ERR_FLAGS_EN
    ,
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc      = 0;
  int dv_cnt   = 0;
  int dv_cyc   = 0;
  int perr_cnt = 0;
  int serr_cnt = 0;
  int n_cmp    = 0;
  int n_bad    = 0;

  // Cycle counter and pulse monitor, sampled 1 time unit after each edge.
  always begin
    @(posedge CLK);
    cyc++;
    #1;
    if (DATA_VALID) begin
      dv_cnt++;
      dv_cyc = cyc;
    end
`ifdef UART_RX_ERR_FLAGS_EN
    if (PAR_ERR) perr_cnt++;
    if (STP_ERR) serr_cnt++;
`endif
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Frame acceptance rule: stop bit high, and parity (if present) matching
  // the even/odd convention over the data byte.
  function automatic bit frame_ok(input bit pe, input bit pt, input logic [7:0] d,
                                  input bit par_bit, input bit stop_bit);
    return stop_bit && (!pe || (par_bit == ((^d) ^ pt)));
  endfunction

  task automatic drive_frame(input int p, input bit pe, input bit pt, input logic [7:0] d,
                             input bit par_bit, input bit stop_bit, output int t0);
    PRESCALE = 6'(p);
    PAR_EN   = pe;
    PAR_TYP  = pt;
    t0       = cyc;
    RX_IN    = 1'b0;
    tick(1);
    // Configuration is latched at the start edge; disturb it mid-frame.
    PRESCALE = 6'(8 + 2 * $urandom_range(0, 12));
    PAR_EN   = 1'($urandom_range(0, 1));
    PAR_TYP  = 1'($urandom_range(0, 1));
    tick(p - 1);
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      tick(p);
    end
    if (pe) begin
      RX_IN = par_bit;
      tick(p);
    end
    RX_IN = stop_bit;
    tick(p);
    RX_IN = 1'b1;
  endtask

  task automatic run_frame(input string tag, input int p, input bit pe, input bit pt,
                           input logic [7:0] d, input bit par_bit, input bit stop_bit,
                           input int idle, input bit exp_ok, input logic [7:0] exp_pd);
    int t0, dv0, pe0, se0;
    RX_IN = 1'b1;
    tick(idle);
    dv0 = dv_cnt;
    pe0 = perr_cnt;
    se0 = serr_cnt;
    drive_frame(p, pe, pt, d, par_bit, stop_bit, t0);
    tick(3);
    check({tag, " valid_pulses"}, dv_cnt - dv0, int'(exp_ok));
    check({tag, " p_data"}, int'(P_DATA), int'(exp_pd));
    if (exp_ok) check({tag, " latency"}, dv_cyc - t0, (10 + int'(pe)) * p);
`ifdef UART_RX_ERR_FLAGS_EN
    check({tag, " par_err_pulses"}, perr_cnt - pe0, int'(pe && (par_bit != ((^d) ^ pt))));
    check({tag, " stp_err_pulses"}, serr_cnt - se0, int'(!stop_bit));
`else
    if (pe0 != perr_cnt || se0 != serr_cnt) check({tag, " err_counters"}, 1, 0);
`endif
  endtask

  typedef struct {
    int         p;
    bit         pe;
    bit         pt;
    logic [7:0] d;
    bit         par;
    bit         stp;
    int         idle;
    bit         ok;
    logic [7:0] pd;
  } vec_t;

  vec_t       tbl[7];
  logic [7:0] model_pd;
  int         t_a, t_b, dv0;

  initial begin
    //           p   pe pt  data   par stp idle ok  p_data
    tbl[0] = '{16, 1, 0, 8'hAA, 0, 1,  5, 1, 8'hAA};
    tbl[1] = '{16, 1, 0, 8'hAA, 0, 1, 25, 1, 8'hAA};
    tbl[2] = '{16, 1, 1, 8'hAA, 0, 1,  5, 0, 8'hAA};
    tbl[3] = '{ 8, 0, 0, 8'h35, 0, 0,  5, 0, 8'hAA};
    tbl[4] = '{ 8, 0, 0, 8'h35, 0, 1,  5, 1, 8'h35};
    tbl[5] = '{32, 1, 1, 8'h5C, 1, 1,  5, 1, 8'h5C};
    tbl[6] = '{ 8, 1, 0, 8'h00, 0, 1,  2, 1, 8'h00};

    RST   = 1'b0;
    RX_IN = 1'b1;
    tick(4);
    check("reset p_data", int'(P_DATA), 0);
    check("reset data_valid", int'(DATA_VALID), 0);
    RST = 1'b1;
    tick(2);

    for (int i = 0; i < 7; i++)
      run_frame($sformatf("vec%0d", i), tbl[i].p, tbl[i].pe, tbl[i].pt, tbl[i].d,
                tbl[i].par, tbl[i].stp, tbl[i].idle, tbl[i].ok, tbl[i].pd);

    // Back-to-back: second start bit immediately follows the first stop bit.
    tick(3);
    dv0 = dv_cnt;
    drive_frame(16, 0, 0, 8'h5A, 0, 1, t_a);
    drive_frame(8, 1, 1, 8'h81, 1, 1, t_b);
    tick(3);
    check("b2b valid_pulses", dv_cnt - dv0, 2);
    check("b2b p_data", int'(P_DATA), 8'h81);
    check("b2b latency", dv_cyc - t_b, 88);

    // Start glitch: 3 low cycles are rejected by the majority vote.
    tick(3);
    PRESCALE = 6'd16;
    PAR_EN   = 1'b0;
    dv0      = dv_cnt;
    RX_IN    = 1'b0;
    tick(3);
    RX_IN = 1'b1;
    tick(20);
    check("glitch valid_pulses", dv_cnt - dv0, 0);
    check("glitch p_data", int'(P_DATA), 8'h81);
    run_frame("after_glitch", 16, 0, 0, 8'h0F, 0, 1, 2, 1, 8'h0F);

    // Reset in the middle of the data bits.
    PRESCALE = 6'd16;
    PAR_EN   = 1'b0;
    dv0      = dv_cnt;
    RX_IN    = 1'b0;
    tick(16);
    RX_IN = 1'b1;
    tick(48);
    RST   = 1'b0;
    tick(1);
    check("midreset p_data", int'(P_DATA), 0);
    check("midreset data_valid", int'(DATA_VALID), 0);
    RST = 1'b1;
    tick(200);
    check("midreset valid_pulses", dv_cnt - dv0, 0);
    run_frame("after_reset", 32, 0, 0, 8'hC3, 0, 1, 3, 1, 8'hC3);

    // Randomized frames against the frame-level model.
    model_pd = 8'hC3;
    for (int n = 0; n < 40; n++) begin
      int         p;
      bit         pe, pt, par, stp, ok;
      logic [7:0] d;
      p   = 8 + 2 * $urandom_range(0, 12);
      pe  = 1'($urandom_range(0, 1));
      pt  = 1'($urandom_range(0, 1));
      d   = 8'($urandom_range(0, 255));
      par = (^d) ^ pt;
      if ($urandom_range(0, 4) == 0) par = ~par;
      stp = ($urandom_range(0, 5) != 0);
      ok  = frame_ok(pe, pt, d, par, stp);
      if (ok) model_pd = d;
      run_frame($sformatf("rand%0d", n), p, pe, pt, d, par, stp,
                $urandom_range(1, 6), ok, model_pd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
